// File: rtl/bram_rd_pipe_if.sv
// Request/response bundle for bram_rd_pipe: valid/ready request channel, FWFT response channel
// and the outstanding-read count. The master drives requests; the slave returns read data.
interface bram_rd_pipe_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int PEND_W     = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_din;
  logic [ID_WIDTH-1:0]   req_id;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_dout;
  logic [ID_WIDTH-1:0]   rsp_id;
  logic [PEND_W-1:0]     rd_pending;

  modport master (
    output req_valid, req_we, req_addr, req_din, req_id, rsp_ready,
    input  req_ready, rsp_valid, rsp_dout, rsp_id, rd_pending
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_din, req_id, rsp_ready,
    output req_ready, rsp_valid, rsp_dout, rsp_id, rd_pending
  );
endinterface

// File: rtl/bram_rd_pipe.sv
// Pipelined BRAM controller: reads return READ_LATENCY cycles after accept, in order, through a FWFT FIFO.
// Back-pressure: req_ready drops once reads in flight plus queued responses reach RSP_DEPTH; the RAM pipe never stalls.
module bram_rd_pipe #(
  parameter int READ_LATENCY = 3,
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = 4,
  parameter int RSP_DEPTH    = 4
) (
  input  logic          clk_a,
  input  logic          arstz_aq,
  bram_rd_pipe_if.slave bus
);
  localparam int PEND_W = $clog2(RSP_DEPTH + 1);
  localparam int IDX_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int STG    = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  logic                  rdy_en_q, rdy_en_d;
  logic [PEND_W-1:0]     pend_q, pend_d;
  logic [STG-1:0]        vld_q, vld_d;
  logic [ID_WIDTH-1:0]   id_q  [STG];
  logic [ID_WIDTH-1:0]   id_d  [STG];
  logic [DATA_WIDTH-1:0] dat_q [STG];
  logic [DATA_WIDTH-1:0] dat_d [STG];
  logic [IDX_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PEND_W-1:0]     cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem_q   [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] fdat_q  [RSP_DEPTH];
  logic [ID_WIDTH-1:0]   fid_q   [RSP_DEPTH];

  logic                  req_acc, wr_acc, rd_acc, ram_en;
  logic                  push, pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] ram_rdat, push_dat;
  logic [ID_WIDTH-1:0]   push_id;

  // Credit depends only on state, so there is no path from request inputs to req_ready.
  assign bus.req_ready  = rdy_en_q & (pend_q < PEND_W'(RSP_DEPTH));
  assign bus.rsp_valid  = ~fifo_empty;
  assign bus.rsp_dout   = fdat_q[rptr_q];
  assign bus.rsp_id     = fid_q[rptr_q];
  assign bus.rd_pending = pend_q;
  assign ram_rdat       = mem_q[bus.req_addr];

  always_comb begin
    req_acc  = bus.req_valid & bus.req_ready;
    wr_acc   = req_acc & bus.req_we;
    rd_acc   = req_acc & ~bus.req_we;
    ram_en   = rd_acc | (|vld_q);
    rdy_en_d = 1'b1;

    vld_d    = vld_q;
    id_d     = id_q;
    dat_d    = dat_q;
    push     = 1'b0;
    push_id  = '0;
    push_dat = '0;

    if (READ_LATENCY == 1) begin
      // Single-cycle latency: the FIFO entry itself acts as the RAM output register.
      vld_d    = '0;
      push     = rd_acc;
      push_id  = bus.req_id;
      push_dat = ram_rdat;
    end else begin
      vld_d[0] = rd_acc;
      if (rd_acc) id_d[0] = bus.req_id;
      if (ram_en) dat_d[0] = ram_rdat;
      for (int i = STG - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        id_d[i]  = id_q[i-1];
        if (ram_en) dat_d[i] = dat_q[i-1];
      end
      push     = vld_q[STG-1];
      push_id  = id_q[STG-1];
      push_dat = dat_q[STG-1];
    end

    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == PEND_W'(RSP_DEPTH));
    pop        = bus.rsp_ready & ~fifo_empty;

    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = (wptr_q == IDX_W'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == IDX_W'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case ({rd_acc, pop})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      rdy_en_q <= 1'b0;
      pend_q   <= '0;
      vld_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      pend_q   <= pend_d;
      vld_q    <= vld_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage arrays carry no reset; the valid bits and pointers above qualify them.
  always_ff @(posedge clk_a) begin
    if (wr_acc) mem_q[bus.req_addr] <= bus.req_din;
    if (push) begin
      fdat_q[wptr_q] <= push_dat;
      fid_q[wptr_q]  <= push_id;
    end
    for (int i = 0; i < STG; i++) begin
      id_q[i]  <= id_d[i];
      dat_q[i] <= dat_d[i];
    end
  end

  a_no_overflow: assert property (@(posedge clk_a) disable iff (!arstz_aq)
    !(push && fifo_full && !pop));

endmodule
